// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply and restoring divide on magnitudes.
// Optional macro MULDIV_DIV0_FLAG_EN adds a div_by_zero output pulsed alongside done.
module mips_muldiv #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic                  div_by_zero
`endif
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q, neg_a_q, neg_b_q, div0_q;
  logic [W-1:0]    mag_a_q, mag_b_q, p_hi_q, p_lo_q;

  logic            neg_a_in, neg_b_in;
  logic [W-1:0]    mag_a_in, mag_b_in;
  logic [W:0]      mul_sum, div_shift;
  logic            div_ge;
  logic [W-1:0]    div_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    res_hi, res_lo;
  logic            last_iter;

  assign busy      = (state_q != IDLE);
  assign last_iter = (cnt_q == CW'(DATA_WIDTH - 1));

  always_comb begin
    neg_a_in = ~op[0] & data_in1[W-1];
    neg_b_in = ~op[0] & data_in2[W-1];
    mag_a_in = neg_a_in ? -data_in1 : data_in1;
    mag_b_in = neg_b_in ? -data_in2 : data_in2;
  end

  // P register pair doubles as product accumulator and remainder:quotient shifter.
  always_comb begin
    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mag_a_q} : '0);
    div_shift = {p_hi_q, p_lo_q[W-1]};
    div_ge    = (div_shift >= {1'b0, mag_b_q});
    div_diff  = div_shift[W-1:0] - mag_b_q;
  end

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -{p_hi_q, p_lo_q} : {p_hi_q, p_lo_q};
    res_hi   = prod_fix[2*W-1:W];
    res_lo   = prod_fix[W-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        // Reconstruct the raw dividend from its latched magnitude and sign.
        res_hi = neg_a_q ? -mag_a_q : mag_a_q;
        res_lo = '1;
      end else begin
        res_hi = neg_a_q ? -p_hi_q : p_hi_q;
        res_lo = (neg_a_q ^ neg_b_q) ? -p_lo_q : p_lo_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_a_q  <= neg_a_in;
            neg_b_q  <= neg_b_in;
            div0_q   <= op[1] && (data_in2 == '0);
            mag_a_q  <= mag_a_in;
            mag_b_q  <= mag_b_in;
            p_hi_q   <= '0;
            p_lo_q   <= op[1] ? mag_a_in : mag_b_in;
          end else begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            p_hi_q <= div_ge ? div_diff : div_shift[W-1:0];
            p_lo_q <= {p_lo_q[W-2:0], div_ge};
          end else begin
            p_hi_q <= mul_sum[W:1];
            p_lo_q <= {mul_sum[0], p_lo_q[W-1:1]};
          end
        end
        FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_by_zero <= 1'b0;
    else        div_by_zero <= (state_q == FIX) && is_div_q && div0_q;
  end
`endif

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed corner cases plus random ops against an arithmetic model.
// Checks div_by_zero as well when MULDIV_DIV0_FLAG_EN is defined.
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] data_in1, data_in2, wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div_by_zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi, mlo;

  mips_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .data_in1(data_in1), .data_in2(data_in2),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DIV0_FLAG_EN
    , .div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = $signed(a); sb = $signed(b);
    ua = {32'h0, a}; ub = {32'h0, b};
    case (o)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          sq = sa / sb; sr = sa % sb;
          return {sr[31:0], sq[31:0]};
        end
        uq = ua / ub; ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int busy_cycles;
    bit seen;
    exp = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; data_in1 = a; data_in2 = b;
    @(negedge clk);
    start = 1'b0; data_in1 = $urandom; data_in2 = $urandom;
    busy_cycles = 0; seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_cycles"}, busy_cycles, 33);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
`ifdef MULDIV_DIV0_FLAG_EN
    check({tag, "_dbz"}, div_by_zero, (o[1] && b == 32'h0));
`endif
    mhi = exp[63:32]; mlo = exp[31:0];
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
`ifdef MULDIV_DIV0_FLAG_EN
    check({tag, "_dbz_pulse"}, div_by_zero, 0);
`endif
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; data_in1 = '0; data_in2 = '0; wr_data = '0;
    mhi = '0; mlo = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    check("mult_neg3x7_hi_const", mhi, 64'hFFFF_FFFF);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("div_minneg", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_by0", 2'd3, 32'h0000_0064, 32'h0);
    run_op("div_by0_neg", 2'd2, 32'hFFFF_FF00, 32'h0);
    run_op("mult_minneg_sq", 2'd0, 32'h8000_0000, 32'h8000_0000);
    run_op("div_7_neg2", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE);

    // MULT 5x6 with an ignored mid-flight start and ignored MTHI/MTLO strobes.
    @(negedge clk);
    start = 1'b1; op = 2'd0; data_in1 = 32'd5; data_in2 = 32'd6;
    hi_we = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("seq_busy", busy, 1);
    check("seq_hi_hold_start", hi, mhi);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd3; data_in1 = 32'd100; data_in2 = 32'd7;
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("seq_hi_hold_busy", hi, mhi);
    check("seq_lo_hold_busy", lo, mlo);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("seq_done_seen", seen, 1);
    check("seq_hi", hi, 32'h0);
    check("seq_lo", lo, 32'h1E);
    hi_we = 1'b1; wr_data = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h1E);
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_hi", hi, 32'hCAFE_F00D);
    check("mthilo_lo", lo, 32'hCAFE_F00D);
    mhi = 32'hCAFE_F00D; mlo = 32'hCAFE_F00D;

    // Reset in the middle of a MULT abandons it.
    @(negedge clk);
    start = 1'b1; op = 2'd0; data_in1 = 32'h0001_2345; data_in2 = 32'h0006_789A;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", seen, 0);
    check("midrst_hi_held", hi, 0);
    run_op("post_rst_multu", 2'd1, 32'd3, 32'd4);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick(), pick());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
